timer_apb_slave: RTL and testbench
==================================

// Module: timer_apb_slave
// PURPOSE
//  APB3 completer (slave) register block for the 8-bit timer IP; terminates CPU-side apb_write/apb_read cycles.
//  Holds TDR (load value), TCR (control) and TSR (sticky status); exposes TCNT read-only.
//  Drives control fields to the counter core and captures its overflow/underflow pulses.
//  Sits between the APB bus and the timer counter; single clock domain.
// PARAMETERS
//  WAIT_STATES  1  pready de-asserted cycles inserted in ACCESS phase (0..3); 0 = zero-wait completion
// PORTS
//  pclk       in   1  APB clock; all logic rising-edge
//  presetn    in   1  asynchronous active-low reset
//  psel       in   1  APB select
//  penable    in   1  APB access phase
//  pwrite     in   1  1 = write, 0 = read
//  paddr      in   8  byte address: 0x00 TDR, 0x01 TCR, 0x02 TSR, 0x03 TCNT
//  pwdata     in   8  write data
//  prdata     out  8  read data, valid when pready=1 in ACCESS
//  pready     out  1  transfer completion
//  pslverr    out  1  error response, valid with pready
//  tdr_o      out  8  TDR value to counter
//  load_o     out  1  TCR[7]: counter loads TDR while set
//  down_o     out  1  TCR[5]: 1 = count down, 0 = count up
//  en_o       out  1  TCR[4]: count enable
//  cks_o      out  2  TCR[1:0]: clock-divider select (pclk/2,/4,/8,/16)
//  tcnt_i     in   8  live counter value
//  ovf_i      in   1  one-cycle overflow pulse from counter (0xFF->0x00, up)
//  udf_i      in   1  one-cycle underflow pulse from counter (0x00->0xFF, down)
// BEHAVIOUR
//  - Reset (async, presetn=0): TDR=0x00, TCR=0x00, TSR=0x00, prdata=0x00, pready=0, pslverr=0; FSM->IDLE.
//  - FSM IDLE -> SETUP on psel&!penable; SETUP -> ACCESS on psel&penable; ACCESS counts WAIT_STATES cycles
//    with pready=0, then one cycle pready=1 -> IDLE (psel&!penable that cycle -> SETUP, back-to-back).
//  - psel dropped mid-ACCESS: abort to IDLE, no register update, pready stays 0.
//  - Register write and prdata capture occur only in the pready=1 cycle; prdata held until next read completes.
//  - TCR writable bits [7],[5],[4],[1:0]; bits [6],[3:2] write-ignored, read 0.
//  - TSR bit0 OVF, bit1 UDF, sticky: set by ovf_i/udf_i; cleared by writing 0 to that bit; writing 1 no effect;
//    bits [7:2] read 0. Same-cycle hardware set and software clear: set wins (TSR bit=1).
//  - TCNT read-only; write to 0x03 -> pslverr=1, no state change. Address >0x03 read or write -> pslverr=1,
//    prdata=0x00. pslverr only asserted alongside pready=1; otherwise 0.
//  - Output fields combinationally from register flops (zero added latency); new TCR visible the cycle after
//    the completing write edge.
//  - ovf_i/udf_i sampled every cycle regardless of bus activity; no pulse lost during wait states.
// STRUCTURE
//  - Shared package timer_pkg: address constants ADDR_TDR/TCR/TSR/TCNT, TCR bit indices, TSR bit indices,
//    FSM state enum {IDLE, SETUP, ACCESS}.
//  - No sub-module required; optional timer_apb_fsm for bus-phase tracking and wait counter.
// TESTING
//  - Reset: presetn=0 mid-ACCESS -> all outputs 0, registers read back 0x00 after release.
//  - Write TDR=0xA5, TCR=0x80, then TCR=0x10 -> tdr_o=0xA5, load_o=1 then 0, en_o=1, down_o=0; TCR readback 0x10.
//  - Write TCR=0xFF -> readback 0xB3; cks_o=3, down_o=1, en_o=1, load_o=1.
//  - Pulse ovf_i once -> TSR reads 0x01; write TSR=0x00 -> reads 0x00; write 0x01 with no pulse -> stays 0x00.
//  - ovf_i pulse in same cycle as TSR=0x00 write completes -> TSR reads 0x01.
//  - WAIT_STATES=2: pready low exactly 2 ACCESS cycles; write 0x03 or read 0x10 -> pslverr=1, prdata=0x00.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit timer APB register block: register map,
// control/status bit positions and the bus-phase state encoding.
package timer_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int TCR_LOAD_BIT = 7;
    localparam int TCR_DOWN_BIT = 5;
    localparam int TCR_EN_BIT   = 4;
    localparam int TCR_CKS_LSB  = 0;

    // Implemented TCR bits; the rest are write-ignored and read as zero.
    localparam logic [7:0] TCR_WMASK = 8'hB3;

    localparam int TSR_OVF_BIT = 0;
    localparam int TSR_UDF_BIT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/timer_apb_fsm.sv
// APB bus-phase tracker: follows SETUP/ACCESS and raises pready after the
// configured number of wait cycles; an access abandoned by the requester never completes.
module timer_apb_fsm
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    output logic       pready,
    output apb_state_e state_o
);

    localparam logic [1:0] WAIT_CNT_LAST = 2'(WAIT_STATES);

    apb_state_e state_q, state_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pready     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) state_d = SETUP;
            end
            SETUP: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    // The SETUP-state cycle with penable high is the first ACCESS cycle.
                    if (WAIT_STATES == 0) begin
                        pready  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d    = ACCESS;
                        wait_cnt_d = 2'd1;
                    end
                end
            end
            ACCESS: begin
                if (!psel || !penable) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_CNT_LAST) begin
                    pready  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/timer_apb_slave.sv
// APB3 completer for the 8-bit timer: TDR/TCR/TSR registers, read-only TCNT,
// control fields to the counter core and sticky overflow/underflow capture.
module timer_apb_slave
    import timer_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic [7:0] tdr_o,
    output logic       load_o,
    output logic       down_o,
    output logic       en_o,
    output logic [1:0] cks_o,
    input  logic [7:0] tcnt_i,
    input  logic       ovf_i,
    input  logic       udf_i
);

    apb_state_e state;
    logic       done;
    logic       addr_err;
    logic       wr_ok;
    logic       rd_done;
    logic [7:0] rdata_mux;

    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic [7:0] tsr_q, tsr_d;
    logic [7:0] prdata_q, prdata_d;

    timer_apb_fsm #(
        .WAIT_STATES(WAIT_STATES)
    ) u_fsm (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pready  (done),
        .state_o (state)
    );

    always_comb begin
        addr_err = (paddr > ADDR_TCNT) || (pwrite && (paddr == ADDR_TCNT));
        wr_ok    = done && pwrite && !addr_err;
        rd_done  = done && !pwrite;

        unique case (paddr)
            ADDR_TDR:  rdata_mux = tdr_q;
            ADDR_TCR:  rdata_mux = tcr_q;
            ADDR_TSR:  rdata_mux = tsr_q;
            ADDR_TCNT: rdata_mux = tcnt_i;
            default:   rdata_mux = 8'h00;
        endcase
    end

    always_comb begin
        tdr_d    = tdr_q;
        tcr_d    = tcr_q;
        tsr_d    = tsr_q;
        prdata_d = prdata_q;

        if (wr_ok && (paddr == ADDR_TDR)) tdr_d = pwdata;
        if (wr_ok && (paddr == ADDR_TCR)) tcr_d = pwdata & TCR_WMASK;
        // Write-zero-to-clear; hardware set is applied last so it wins a same-cycle clear.
        if (wr_ok && (paddr == ADDR_TSR)) tsr_d = tsr_q & pwdata;
        tsr_d[TSR_OVF_BIT] = tsr_d[TSR_OVF_BIT] | ovf_i;
        tsr_d[TSR_UDF_BIT] = tsr_d[TSR_UDF_BIT] | udf_i;
        tsr_d[7:2]         = 6'd0;

        if (rd_done) prdata_d = rdata_mux;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q    <= 8'h00;
            tcr_q    <= 8'h00;
            tsr_q    <= 8'h00;
            prdata_q <= 8'h00;
        end else begin
            tdr_q    <= tdr_d;
            tcr_q    <= tcr_d;
            tsr_q    <= tsr_d;
            prdata_q <= prdata_d;
        end
    end

    // Read data is presented in the completing cycle itself and held afterwards.
    assign prdata  = rd_done ? rdata_mux : prdata_q;
    assign pready  = done;
    assign pslverr = done && addr_err;

    assign tdr_o  = tdr_q;
    assign load_o = tcr_q[TCR_LOAD_BIT];
    assign down_o = tcr_q[TCR_DOWN_BIT];
    assign en_o   = tcr_q[TCR_EN_BIT];
    assign cks_o  = tcr_q[TCR_CKS_LSB +: 2];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Directed bench for timer_apb_slave with two wait states: a vector table of
// APB transfers plus hand sequences for sticky status, abort and reset.
module tb_timer_apb_slave;

    localparam int WS = 2;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready, pslverr;
    logic [7:0] tdr_o;
    logic       load_o, down_o, en_o;
    logic [1:0] cks_o;
    logic [7:0] tcnt_i;
    logic       ovf_i, udf_i;

    int n_tests = 0;
    int n_fail  = 0;

    timer_apb_slave #(.WAIT_STATES(WS)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tdr_o   (tdr_o),
        .load_o  (load_o),
        .down_o  (down_o),
        .en_o    (en_o),
        .cks_o   (cks_o),
        .tcnt_i  (tcnt_i),
        .ovf_i   (ovf_i),
        .udf_i   (udf_i)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        string      name;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic [7:0] exp_tdr;
        logic [4:0] exp_ctl;   // {load, down, en, cks[1:0]}
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rdata,
                       input logic exp_err, input logic [7:0] exp_tdr, input logic [4:0] exp_ctl);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_tdr = exp_tdr; v.exp_ctl = exp_ctl;
        vecs.push_back(v);
    endtask

    // pmode: 0 no pulse, 1 ovf_i pulse in the completing cycle, 2 ovf_i pulse in the first wait cycle
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input int pmode, output logic [7:0] rdata, output logic err,
                            output int waits);
        logic done;
        done  = 1'b0;
        waits = 0;
        rdata = 8'h00;
        err   = 1'b0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge pclk);
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                done  = 1'b1;
                if (pmode == 1) ovf_i = 1'b1;
            end else begin
                if (pmode == 2 && waits == 0) ovf_i = 1'b1;
                waits++;
            end
            @(posedge pclk); #1;
            ovf_i = 1'b0;
        end
        psel = 1'b0; penable = 1'b0;
        if (!done) check("pready_timeout", 32'(done), 32'd1);
    endtask

    task automatic rd(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] r; logic e; int w;
        apb_xfer(1'b0, addr, 8'h00, 0, r, e, w);
        check(name, 32'(r), 32'(exp));
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data, input int pmode);
        logic [7:0] r; logic e; int w;
        apb_xfer(1'b1, addr, data, pmode, r, e, w);
    endtask

    task automatic pulse(input logic is_udf);
        @(posedge pclk); #1;
        if (is_udf) udf_i = 1'b1; else ovf_i = 1'b1;
        @(posedge pclk); #1;
        udf_i = 1'b0; ovf_i = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({prdata, pready, pslverr, tdr_o, load_o, down_o, en_o, cks_o});
    endfunction

    initial begin
        logic [7:0] r;
        logic       e;
        int         w;

        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
        tcnt_i = 8'h3C; ovf_i = 1'b0; udf_i = 1'b0;

        add("rd_tdr_rst",  1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 5'b00000);
        add("wr_tdr_a5",   1'b1, 8'h00, 8'hA5, 8'h00, 1'b0, 8'hA5, 5'b00000);
        add("wr_tcr_80",   1'b1, 8'h01, 8'h80, 8'h00, 1'b0, 8'hA5, 5'b10000);
        add("wr_tcr_10",   1'b1, 8'h01, 8'h10, 8'h00, 1'b0, 8'hA5, 5'b00100);
        add("rd_tcr_10",   1'b0, 8'h01, 8'h00, 8'h10, 1'b0, 8'hA5, 5'b00100);
        add("rd_tdr_a5",   1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 8'hA5, 5'b00100);
        add("wr_tcr_ff",   1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 8'hA5, 5'b11111);
        add("rd_tcr_b3",   1'b0, 8'h01, 8'h00, 8'hB3, 1'b0, 8'hA5, 5'b11111);
        add("wr_tcnt_err", 1'b1, 8'h03, 8'h55, 8'h00, 1'b1, 8'hA5, 5'b11111);
        add("rd_x10_err",  1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 8'hA5, 5'b11111);
        add("rd_tcnt",     1'b0, 8'h03, 8'h00, 8'h3C, 1'b0, 8'hA5, 5'b11111);
        add("wr_x10_err",  1'b1, 8'h10, 8'hFF, 8'h00, 1'b1, 8'hA5, 5'b11111);
        add("rd_tcr_keep", 1'b0, 8'h01, 8'h00, 8'hB3, 1'b0, 8'hA5, 5'b11111);
        add("rd_tsr_0",    1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 8'hA5, 5'b11111);
        add("wr_tdr_5a",   1'b1, 8'h00, 8'h5A, 8'h00, 1'b0, 8'h5A, 5'b11111);
        add("wr_tcr_00",   1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 8'h5A, 5'b00000);
        add("wr_tcr_4c",   1'b1, 8'h01, 8'h4C, 8'h00, 1'b0, 8'h5A, 5'b00000);
        add("rd_tcr_ign",  1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 8'h5A, 5'b00000);
        add("rd_tdr_5a",   1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, 8'h5A, 5'b00000);

        repeat (3) @(posedge pclk);
        #1;
        check("reset_outputs", all_outs(), 32'd0);
        presetn = 1'b1;

        foreach (vecs[i]) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, r, e, w);
            if (!vecs[i].wr) check({vecs[i].name, "_rdata"}, 32'(r), 32'(vecs[i].exp_rdata));
            check({vecs[i].name, "_pslverr"}, 32'(e), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_waits"}, 32'(w), WS);
            @(negedge pclk);
            check({vecs[i].name, "_tdr_o"}, 32'(tdr_o), 32'(vecs[i].exp_tdr));
            check({vecs[i].name, "_ctl"}, 32'({load_o, down_o, en_o, cks_o}), 32'(vecs[i].exp_ctl));
        end

        // Read data is held across a following write.
        wr(8'h01, 8'h00, 0);
        @(negedge pclk);
        check("prdata_hold", 32'(prdata), 32'h5A);

        // Sticky status: set, clear by writing 0, writing 1 has no effect.
        pulse(1'b0);
        rd("tsr_ovf_set", 8'h02, 8'h01);
        wr(8'h02, 8'h00, 0);
        rd("tsr_cleared", 8'h02, 8'h00);
        wr(8'h02, 8'h01, 0);
        rd("tsr_w1_noeff", 8'h02, 8'h00);
        pulse(1'b1);
        rd("tsr_udf_set", 8'h02, 8'h02);
        wr(8'h02, 8'h00, 1);
        rd("tsr_set_wins", 8'h02, 8'h01);
        wr(8'h02, 8'h00, 0);
        rd(8'h00 == 8'h00 ? "tsr_clear2" : "tsr_clear2", 8'h02, 8'h00);
        wr(8'h00, 8'h5A, 2);
        rd("tsr_pulse_in_wait", 8'h02, 8'h01);

        // Abort: psel dropped after the first access cycle.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort_pready_a", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("abort_pready_b", 32'({pready, pslverr}), 32'd0);
        repeat (3) @(posedge pclk);
        #1;
        check("abort_tdr_o", 32'(tdr_o), 32'h5A);
        rd("abort_tdr_rd", 8'h00, 8'h5A);

        // Reset asserted in the middle of an access.
        wr(8'h01, 8'hFF, 0);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        check("midreset_outputs", all_outs(), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        rd("midreset_tdr", 8'h00, 8'h00);
        rd("midreset_tcr", 8'h01, 8'h00);
        rd("midreset_tsr", 8'h02, 8'h00);

        repeat (2) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
